tea_sync_encryptor: RTL and testbench

TEA_SYNC_ENCRYPTOR -- requirements
Module: tea_sync_encryptor

---
 rtl/tea_sync_encryptor.sv | 79 +++++++
 tb/tb_tea_sync_encryptor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_sync_encryptor.sv
// Iterative TEA block encryptor: one full TEA cycle per enabled clock, ROUNDS-clock latency.
// Ciphertext is held in DONE until out_ready; a new block may be accepted on the same edge it is consumed.
module tea_sync_encryptor #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  state_t       state_q;
  logic [31:0]  v0_q, v1_q, sum_q;
  logic [31:0]  v0_d, v1_d, sum_d;
  logic [127:0] key_q;
  logic [4:0]   cnt_q;
  logic         accept;

  // v1 update uses the freshly computed v0 and the already-advanced sum.
  always_comb begin
    sum_d = sum_q + DELTA;
    v0_d  = v0_q + (((v1_q << 4) + key_q[127:96]) ^ (v1_q + sum_d) ^ ((v1_q >> 5) + key_q[95:64]));
    v1_d  = v1_q + (((v0_d << 4) + key_q[63:32]) ^ (v0_d + sum_d) ^ ((v0_d >> 5) + key_q[31:0]));
  end

  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == RUN);
  assign outBlock64 = {v0_q, v1_q};
  assign accept     = ena & in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else if (ena) begin
      case (state_q)
        RUN: begin
          sum_q <= sum_d;
          v0_q  <= v0_d;
          v1_q  <= v1_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_RND) state_q <= DONE;
        end
        default: begin
          if (accept) begin
            v0_q    <= inBlock64[63:32];
            v1_q    <= inBlock64[31:0];
            key_q   <= key;
            sum_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else if (state_q == DONE) begin
            if (out_ready) state_q <= IDLE;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tea_sync_encryptor.sv
// Scoreboard bench for tea_sync_encryptor: stimulus queues expected ciphertext and latency,
// a negedge monitor checks each block as it is presented and consumed.
module tb_tea_sync_encryptor;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst, ena, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]  inBlock64, outBlock64;
  logic [127:0] key;

  tea_sync_encryptor #(.ROUNDS(32), .DELTA(DELTA)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inBlock64 (inBlock64),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outBlock64(outBlock64),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pt;
    logic [63:0] ct;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] tea_enc(input logic [63:0] b, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = b[63:32]; v1 = b[31:0]; sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + DELTA;
      v0  = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
      v1  = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] b, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = b[63:32]; v1 = b[31:0]; sum = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      v1  = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
      v0  = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
      sum = sum - DELTA;
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor: latency on first sight of out_valid, data on the consuming edge.
  always @(negedge clk) begin
    int   lat;
    exp_t e;
    if (rst) begin
      acc_q.delete();
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output got=%h required=no_output", outBlock64);
        end else begin
          lat = cyc - acc_q.pop_front();
          chk("latency", 64'(lat), 64'(exp_q[0].lat));
        end
      end
      if (ena && out_valid && out_ready) begin
        seen = 1'b0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ciphertext", outBlock64, e.ct);
          chk("roundtrip", tea_dec(outBlock64, key_of(e)), e.pt);
        end
      end
      if (ena && in_valid && in_ready) acc_q.push_back(cyc + 1);
    end
  end

  // Keys are recovered from a side table keyed by issue order.
  logic [127:0] key_tab[$];
  function automatic logic [127:0] key_of(input exp_t e);
    logic [127:0] k;
    k = key_tab.pop_front();
    return (e.lat >= 0) ? k : 128'd0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [63:0] pt, input logic [127:0] k, input logic [63:0] ct,
                      input int lat, input bit keep);
    int n = 0;
    inBlock64 = pt; key = k; in_valid = 1'b1;
    while (!(in_ready && ena) && n < 200) begin step(); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL accept_timeout got=in_ready_low required=in_ready_high");
    end
    if (keep) begin
      exp_q.push_back('{pt, ct, lat});
      key_tab.push_back(k);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin step(); n++; end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
    end
  endtask

  logic [63:0]  vpt[3];
  logic [127:0] vkey[3];

  initial begin
    logic [63:0]  hold, p;
    logic [127:0] k;
    int           n;
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    inBlock64 = '0; key = '0;
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out", outBlock64, 64'd0);
    rst = 1'b0;
    step();

    // Known answer, all-zero key and plaintext.
    send(64'd0, 128'd0, 64'h41EA3A0A_94BAA940, 32, 1'b1);
    chk("busy_after_accept", 64'(busy), 64'd1);
    drain();

    // Directed vectors issued back to back.
    vpt[0] = 64'h01234567_89ABCDEF; vkey[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    vpt[1] = 64'hFFFFFFFF_FFFFFFFF; vkey[1] = {4{32'hFFFFFFFF}};
    vpt[2] = 64'h80000000_00000001; vkey[2] = 128'h00000001_00000002_00000003_00000004;
    for (int i = 0; i < 3; i++) send(vpt[i], vkey[i], tea_enc(vpt[i], vkey[i]), 32, 1'b1);
    drain();

    // Random back-to-back round trips.
    for (int i = 0; i < 20; i++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send(p, k, tea_enc(p, k), 32, 1'b1);
    end
    drain();

    // Backpressure hold in DONE, then consume and accept on one edge.
    out_ready = 1'b0;
    send(vpt[0], vkey[2], tea_enc(vpt[0], vkey[2]), 32, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    hold = outBlock64;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_stable", outBlock64, hold);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    inBlock64 = vpt[1]; key = vkey[0]; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back('{vpt[1], tea_enc(vpt[1], vkey[0]), 32});
    key_tab.push_back(vkey[0]);
    step();
    in_valid = 1'b0;
    chk("bp_busy_next", 64'(busy), 64'd1);
    drain();

    // Enable dropped for 7 cycles mid-run.
    send(vpt[2], vkey[1], tea_enc(vpt[2], vkey[1]), 39, 1'b1);
    repeat (10) step();
    ena = 1'b0;
    repeat (7) step();
    ena = 1'b1;
    drain();

    // Reset during round 15 discards the block.
    send(vpt[0], vkey[0], 64'd0, 0, 1'b0);
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out", outBlock64, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    send(vpt[1], vkey[2], tea_enc(vpt[1], vkey[2]), 32, 1'b1);
    drain();

    // Inputs scrambled every cycle while the block is in flight.
    send(vpt[2], vkey[0], tea_enc(vpt[2], vkey[0]), 32, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      inBlock64 = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      step();
      n++;
    end
    drain();
    step();
    chk("final_in_ready", 64'(in_ready), 64'd1);
    chk("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

endmodule
